// File: rtl/dm_sba_arb.sv
// Two-requester round-robin arbiter onto one shared bus, one transaction in flight.
// Optional response timeout when DM_SBA_ARB_TIMEOUT_EN is defined.
//
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   req_i/add_i/we_i/
//   wdata_i/be_i          per-requester request, requester n in slice n
//   gnt_o, r_valid_o,
//   r_err_o, r_rdata_o    per-requester grant/response (rdata shared)
//   master_*_o            shared bus request driven from the owner's slices
//   master_*_i            shared bus grant and response
module dm_sba_arb #(
    parameter int BusWidth      = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [1:0]              req_i,
    input  logic [2*BusWidth-1:0]   add_i,
    input  logic [1:0]              we_i,
    input  logic [2*BusWidth-1:0]   wdata_i,
    input  logic [2*BusWidth/8-1:0] be_i,
    output logic [1:0]              gnt_o,
    output logic [1:0]              r_valid_o,
    output logic [BusWidth-1:0]     r_rdata_o,
    output logic [1:0]              r_err_o,
    output logic                    master_req_o,
    output logic [BusWidth-1:0]     master_add_o,
    output logic                    master_we_o,
    output logic [BusWidth-1:0]     master_wdata_o,
    output logic [BusWidth/8-1:0]   master_be_o,
    input  logic                    master_gnt_i,
    input  logic                    master_r_valid_i,
    input  logic [BusWidth-1:0]     master_r_rdata_i
);

    localparam int BeW = BusWidth / 8;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StWait = 2'd2;

    logic [1:0] state_q, state_d;
    logic       owner_q, owner_d;
    logic       ptr_q, ptr_d;
    logic       sel;
    logic       in_req, in_wait;
    logic       timeout;
    logic [1:0] own_mask;

    // Pointer names the preferred requester; the other wins only if it is idle.
    assign sel      = req_i[ptr_q] ? ptr_q : ~ptr_q;
    assign in_req   = (state_q == StReq);
    assign in_wait  = (state_q == StWait);
    assign own_mask = owner_q ? 2'b10 : 2'b01;

`ifdef DM_SBA_ARB_TIMEOUT_EN
    logic [15:0] cnt_q;

    // A response arriving in the timeout cycle takes precedence.
    assign timeout = in_wait && (cnt_q == 16'(TimeoutCycles))
                     && !master_r_valid_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (in_req && master_gnt_i) begin
            cnt_q <= '0;
        end else if (in_wait) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end
`else
    // No counter: wait for the response indefinitely. The legal range of
    // TimeoutCycles starts at 1, so this folds to constant 0.
    assign timeout = (TimeoutCycles < 0);
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (|req_i) begin
                    owner_d = sel;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (master_gnt_i) begin
                    state_d = StWait;
                    ptr_d   = ~owner_q;
                end
            end
            StWait: begin
                if (master_r_valid_i || timeout) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // Bus side: only the owner's slices, and only while requesting.
    always_comb begin
        master_req_o   = in_req;
        master_add_o   = '0;
        master_we_o    = 1'b0;
        master_wdata_o = '0;
        master_be_o    = '0;
        if (in_req) begin
            if (owner_q) begin
                master_add_o   = add_i[2*BusWidth-1:BusWidth];
                master_we_o    = we_i[1];
                master_wdata_o = wdata_i[2*BusWidth-1:BusWidth];
                master_be_o    = be_i[2*BeW-1:BeW];
            end else begin
                master_add_o   = add_i[BusWidth-1:0];
                master_we_o    = we_i[0];
                master_wdata_o = wdata_i[BusWidth-1:0];
                master_be_o    = be_i[BeW-1:0];
            end
        end
    end

    // Requester side: responses outside WaitResp are stale and dropped.
    always_comb begin
        gnt_o     = '0;
        r_valid_o = '0;
        r_err_o   = '0;
        r_rdata_o = '0;
        if (in_req && master_gnt_i) begin
            gnt_o = own_mask;
        end
        if (in_wait && master_r_valid_i) begin
            r_valid_o = own_mask;
            r_rdata_o = master_r_rdata_i;
        end else if (timeout) begin
            r_valid_o = own_mask;
            r_err_o   = own_mask;
        end
    end

endmodule

// File: doc/dm_sba_arb.md
DM_SBA_ARB -- requirements
Module: dm_sba_arb

Interface
REQ-001 SHALL have parameter BusWidth, default 32, meaning the address and data width in bits (32 or 64).
REQ-002 SHALL have parameter TimeoutCycles, default 255, meaning the response-wait limit in cycles (1..65535).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock, all state on rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port req_i, input, 2 bits: request per requester (bit0 = SBA, bit1 = secondary master).
REQ-006 SHALL have port add_i, input, 2*BusWidth bits: address per requester, requester n in slice n.
REQ-007 SHALL have port we_i, input, 2 bits: write enable per requester.
REQ-008 SHALL have port wdata_i, input, 2*BusWidth bits: write data per requester.
REQ-009 SHALL have port be_i, input, 2*BusWidth/8 bits: byte enables per requester.
REQ-010 SHALL have port gnt_o, output, 2 bits: grant per requester.
REQ-011 SHALL have port r_valid_o, output, 2 bits: response valid per requester.
REQ-012 SHALL have port r_rdata_o, output, BusWidth bits: read data, shared by both requesters.
REQ-013 SHALL have port r_err_o, output, 2 bits: timeout error, qualified by r_valid_o.
REQ-014 SHALL have ports master_req_o, master_add_o, master_we_o, master_wdata_o and master_be_o, outputs, widths 1/BusWidth/1/BusWidth/BusWidth/8: the shared bus request.
REQ-015 SHALL have ports master_gnt_i, master_r_valid_i and master_r_rdata_i, inputs, widths 1/1/BusWidth: the shared bus grant and response.

Function
REQ-016 SHALL implement FSM states Idle, Req and WaitResp, with one outstanding transaction maximum.
REQ-017 In Idle with any req_i set, SHALL select one requester by round-robin pointer (pointer = preferred index, the other requester wins only if the preferred one is idle), latch the selection as owner, and enter Req.
REQ-018 In Idle, master_req_o SHALL be 0 and gnt_o SHALL be 0.
REQ-019 In Req, SHALL drive master_req_o=1 and the master_add/we/wdata/be outputs from the owner's slices, and drive gnt_o[owner]=master_gnt_i with the other gnt_o bit 0.
REQ-020 In Req, owner SHALL stay fixed until master_gnt_i, regardless of req_i changes.
REQ-021 On master_gnt_i in Req, SHALL enter WaitResp and set the pointer to the non-owner index.
REQ-022 In WaitResp, master_req_o SHALL be 0, r_valid_o[owner] SHALL equal master_r_valid_i, and r_rdata_o SHALL equal master_r_rdata_i; on master_r_valid_i, SHALL return to Idle.
REQ-023 Grant-to-response latency through the block SHALL be 0 added cycles; minimum request-to-grant latency SHALL be 1 cycle (the Idle->Req cycle).
REQ-024 master_r_valid_i in Idle or Req SHALL be ignored (stale response), and r_valid_o SHALL stay 0.
REQ-025 When both requesters continuously request, grants SHALL alternate 0,1,0,1.
REQ-026 Non-owner requests SHALL wait without grant; a requester SHALL hold req_i and its payload until its gnt_o.

Reset
REQ-027 While rst_i is high, SHALL force state=Idle, owner=0, pointer=0, and timeout counter=0.
REQ-028 During reset all outputs SHALL be 0.
REQ-029 Reset mid-transaction SHALL abandon the transaction with no r_valid_o; any later response SHALL be dropped per REQ-024.

Configuration
REQ-030 With macro DM_SBA_ARB_TIMEOUT_EN defined, SHALL clear a 16-bit counter on entry to WaitResp and increment it each WaitResp cycle.
REQ-031 With DM_SBA_ARB_TIMEOUT_EN defined, when the counter reaches TimeoutCycles without master_r_valid_i, SHALL pulse r_valid_o[owner] and r_err_o[owner] for one cycle with r_rdata_o=0, then return to Idle.
REQ-032 With DM_SBA_ARB_TIMEOUT_EN defined, if master_r_valid_i coincides with the timeout cycle, the response SHALL win and r_err_o SHALL be 0.
REQ-033 Without DM_SBA_ARB_TIMEOUT_EN, no counter SHALL exist, WaitResp SHALL wait indefinitely, and r_err_o SHALL be tied to 0.

Verification
REQ-034 Bench SHALL cover single read: req_i=01, add slice0=0x1000, gnt 1 cycle after Req, rdata 0xCAFEF00D 2 cycles later -> gnt_o=01 once, r_valid_o=01 once, r_rdata_o=0xCAFEF00D.
REQ-035 Bench SHALL cover contention: req_i=11 held for 4 transactions -> owners 0,1,0,1, with master_add_o alternating slice0/slice1.
REQ-036 Bench SHALL cover lock: owner 1 in Req, gnt withheld 5 cycles, req_i toggles bit0 -> master_add_o stays slice1 for all 5 cycles, gnt_o[0]=0.
REQ-037 Bench SHALL cover timeout: macro defined, TimeoutCycles=8, no response -> r_valid_o[owner]=1 and r_err_o[owner]=1 exactly 8 cycles after entry to WaitResp, then a late r_valid ignored; macro undefined -> still in WaitResp after 1000 cycles.
REQ-038 Bench SHALL cover reset: rst_i pulsed in WaitResp, then master_r_valid_i=1 -> r_valid_o=00, state Idle, next grant goes to requester 0.
